// File: rtl/fetch_pkg.sv
// Shared defaults and slot type for the fetch front end.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 16;
  localparam int unsigned FETCH_INST_W = 16;
  // Stale-response counter; wide enough for several back-to-back redirects.
  localparam int unsigned DROP_CNT_W   = 8;

  localparam logic [FETCH_INST_W-1:0] NOP_INST = '0;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_INST_W-1:0] inst;
    logic                    filled;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_slot_queue.sv
// In-order slot queue: a slot is allocated when a request is accepted, filled when its
// response returns and popped by decode once filled.
module fetch_slot_queue
  import fetch_pkg::*;
#(
  parameter int unsigned               DEPTH    = 2,
  parameter logic [FETCH_ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      alloc_i,
  input  logic [FETCH_ADDR_W-1:0]   alloc_pc_i,
  input  logic                      fill_i,
  input  logic [FETCH_INST_W-1:0]   fill_data_i,
  input  logic                      pop_i,
  output logic [FETCH_ADDR_W-1:0]   head_pc_o,
  output logic [FETCH_INST_W-1:0]   head_inst_o,
  output logic                      head_valid_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [$clog2(DEPTH):0]    unfilled_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fetch_slot_t     slots_q [DEPTH];
  fetch_slot_t     slots_d [DEPTH];
  logic [PtrW-1:0] head_q, head_d, alloc_q, alloc_d, fill_q, fill_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] pend_diff;

  always_comb begin
    slots_d = slots_q;
    head_d  = head_q;
    alloc_d = alloc_q;
    fill_d  = fill_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      alloc_d = '0;
      fill_d  = '0;
      count_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slots_d[i].filled = 1'b0;
      end
    end else begin
      if (alloc_i) begin
        slots_d[alloc_q].pc     = alloc_pc_i;
        slots_d[alloc_q].filled = 1'b0;
        alloc_d                 = alloc_q + PtrW'(1);
      end
      if (fill_i) begin
        slots_d[fill_q].inst   = fill_data_i;
        slots_d[fill_q].filled = 1'b1;
        fill_d                 = fill_q + PtrW'(1);
      end
      if (pop_i) begin
        head_d = head_q + PtrW'(1);
      end
      count_d = count_q + CntW'(alloc_i) - CntW'(pop_i);
    end
  end

  // alloc == fill is ambiguous when full: the fill slot's flag tells all-filled from none-filled.
  always_comb begin
    pend_diff  = alloc_q - fill_q;
    unfilled_o = {1'b0, pend_diff};
    if (alloc_q == fill_q && count_q == CntW'(DEPTH) && !slots_q[fill_q].filled) begin
      unfilled_o = CntW'(DEPTH);
    end
  end

  always_comb begin
    head_pc_o    = slots_q[head_q].pc;
    head_inst_o  = slots_q[head_q].inst;
    head_valid_o = (count_q != '0) && slots_q[head_q].filled;
    count_o      = count_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slots_q[i] <= '{pc: RESET_PC, inst: NOP_INST, filled: 1'b0};
      end
      head_q  <= '0;
      alloc_q <= '0;
      fill_q  <= '0;
      count_q <= '0;
    end else begin
      slots_q <= slots_d;
      head_q  <= head_d;
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage: owns the PC, issues word requests to instruction memory and buffers replies
// for decode. Defining FETCH_PERF_EN adds saturating stall/flush performance counters.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned        INST_W   = FETCH_INST_W,
  parameter int unsigned        DEPTH    = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [INST_W-1:0] inst_fetch,
  output logic [ADDR_W-1:0] PC_fetch,
  output logic [ADDR_W-1:0] PCPlus1
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [ADDR_W-1:0]     head_pc;
  logic [INST_W-1:0]     head_inst;
  logic                  head_valid;
  logic [CntW-1:0]       count, unfilled;
  logic                  alloc, fill, pop, rsp_stale, rsp_keep;

  always_comb begin
    imem_req_valid = rst && !flush && (count < CntW'(DEPTH));
    imem_addr      = pc_q;
    id_valid       = head_valid && !flush;
    PC_fetch       = head_pc;
    PCPlus1        = head_pc + ADDR_W'(1);
    inst_fetch     = id_valid ? head_inst : NOP_INST;
    alloc          = imem_req_valid && imem_req_ready;
    pop            = id_valid && id_ready;
    rsp_stale      = imem_rsp_valid && (drop_cnt_q != '0);
    rsp_keep       = imem_rsp_valid && (drop_cnt_q == '0) && (unfilled != '0);
    fill           = rsp_keep && !flush;
  end

  // On redirect every still-unfilled slot becomes a response to throw away; a response
  // consumed in the same cycle is already one of them.
  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      pc_d       = flush_pc;
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(unfilled) - DROP_CNT_W'(rsp_stale || rsp_keep);
    end else begin
      if (alloc) begin
        pc_d = pc_q + ADDR_W'(1);
      end
      if (rsp_stale) begin
        drop_cnt_d = drop_cnt_q - DROP_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_slot_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_queue (
    .clk_i        (clk),
    .rst_ni       (rst),
    .clear_i      (flush),
    .alloc_i      (alloc),
    .alloc_pc_i   (pc_q),
    .fill_i       (fill),
    .fill_data_i  (imem_rsp_data),
    .pop_i        (pop),
    .head_pc_o    (head_pc),
    .head_inst_o  (head_inst),
    .head_valid_o (head_valid),
    .count_o      (count),
    .unfilled_o   (unfilled)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (id_ready && !id_valid && perf_stall_q != '1) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (flush && perf_flush_q != '1) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

`ifndef SYNTHESIS
  // A response that is not being dropped must have an allocated, unfilled slot to land in.
  rsp_has_slot: assert property (@(posedge clk) disable iff (!rst)
    !(imem_rsp_valid && drop_cnt_q == '0 && unfilled == '0))
    else $error("fetch_prefetch: instruction response with no outstanding request");
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: directed vector table, corner sequences and random traffic
// against an epoch-tagged request/response model with an in-order memory.
module tb_fetch_prefetch;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 16;
  localparam int unsigned IW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [AW-1:0] imem_addr, flush_pc, PC_fetch, PCPlus1;
  logic [IW-1:0] imem_rsp_data, inst_fetch;
  logic          flush, id_ready, id_valid;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_stall_cnt, perf_flush_cnt;
  int unsigned   m_stall, m_flush;
`endif

  always #5 clk = ~clk;

  fetch_prefetch #(
    .ADDR_W   (AW),
    .INST_W   (IW),
    .DEPTH    (DEPTH),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .inst_fetch     (inst_fetch),
    .PC_fetch       (PC_fetch),
    .PCPlus1        (PCPlus1)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  typedef struct { logic [AW-1:0] pc; bit got; } ent_t;
  typedef struct { logic [AW-1:0] addr; int epoch; int due; } mreq_t;
  typedef struct {
    bit idr; bit fl; logic [AW-1:0] fpc;
    bit rv; logic [AW-1:0] addr; bit idv; logic [AW-1:0] pc;
  } vec_t;

  ent_t          mq[$];      // current-epoch requests not yet delivered
  mreq_t         memq[$];    // everything the memory still owes, stale or not
  logic [AW-1:0] acc_log[$];
  logic [AW-1:0] deliv_log[$];
  int            cyc, epoch, last_due, n_chk, n_fail, n_acc, lat_min, lat_max;
  logic [AW-1:0] req_pc;
  logic          s_rv, s_idv;
  logic [AW-1:0] s_addr, s_pc, s_plus1;
  logic [IW-1:0] s_inst;
  vec_t          vec[12];

  function automatic logic [IW-1:0] mem_f(input logic [AW-1:0] a);
    return (a * 16'd7) ^ 16'hC35A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    memq.delete();
    acc_log.delete();
    deliv_log.delete();
    epoch++;
    req_pc   = 16'h0000;
    last_due = cyc;
    n_acc    = 0;
`ifdef FETCH_PERF_EN
    m_stall = 0;
    m_flush = 0;
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, imem_req_valid, 0);
    chk({tag, "_id_valid"}, id_valid, 0);
    chk({tag, "_inst"}, inst_fetch, 0);
    chk({tag, "_pc"}, PC_fetch, 16'h0000);
    chk({tag, "_pcplus1"}, PCPlus1, 16'h0001);
`ifdef FETCH_PERF_EN
    chk({tag, "_perf_stall"}, perf_stall_cnt, 0);
    chk({tag, "_perf_flush"}, perf_flush_cnt, 0);
`endif
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    flush          = 1'b0;
    flush_pc       = '0;
    id_ready       = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    model_reset();
    rst = 1'b1;
  endtask

  // One clock: entered at posedge+1 with inputs set by the caller, returns at next posedge+1.
  task automatic step();
    bit            rsp_now, exp_rv, exp_idv;
    int            rsp_ep, d;
    logic [AW-1:0] hp, plus;
    rsp_now = 1'b0;
    rsp_ep  = 0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      rsp_now        = 1'b1;
      rsp_ep         = memq[0].epoch;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_f(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = IW'($urandom);
    end
    #4;
    s_rv    = imem_req_valid;
    s_addr  = imem_addr;
    s_idv   = id_valid;
    s_pc    = PC_fetch;
    s_plus1 = PCPlus1;
    s_inst  = inst_fetch;
    exp_rv  = !flush && (mq.size() < DEPTH);
    exp_idv = !flush && (mq.size() > 0) && mq[0].got;
    chk("req_valid", s_rv, exp_rv);
    if (exp_rv) chk("imem_addr", s_addr, req_pc);
    chk("id_valid", s_idv, exp_idv);
    if (exp_idv) begin
      hp   = mq[0].pc;
      plus = hp + 16'd1;
      chk("PC_fetch", s_pc, hp);
      chk("PCPlus1", s_plus1, plus);
      chk("inst_fetch", s_inst, mem_f(hp));
    end else begin
      chk("inst_idle", s_inst, 0);
    end
`ifdef FETCH_PERF_EN
    chk("perf_stall", perf_stall_cnt, m_stall);
    chk("perf_flush", perf_flush_cnt, m_flush);
    if (id_ready && !exp_idv) m_stall++;
    if (flush) m_flush++;
`endif
    if (flush) begin
      mq.delete();
      acc_log.delete();
      epoch++;
      req_pc = flush_pc;
    end else begin
      if (exp_idv && id_ready) begin
        deliv_log.push_back(mq[0].pc);
        void'(mq.pop_front());
      end
      if (rsp_now && rsp_ep == epoch) begin
        for (int j = 0; j < mq.size(); j++) begin
          if (!mq[j].got) begin
            mq[j].got = 1'b1;
            break;
          end
        end
      end
      if (exp_rv && imem_req_ready) begin
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mq.push_back('{pc: req_pc, got: 1'b0});
        memq.push_back('{addr: req_pc, epoch: epoch, due: d});
        acc_log.push_back(req_pc);
        n_acc++;
        req_pc = req_pc + 16'd1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_deliv(input int n, input int budget);
    int k;
    k = 0;
    while (deliv_log.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("deliv_count", deliv_log.size(), n);
  endtask

  initial begin
    int base;
    int k;
    n_chk   = 0;
    n_fail  = 0;
    cyc     = 0;
    epoch   = 0;
    lat_min = 1;
    lat_max = 1;

    // idr fl fpc  rv addr idv pc : latency 1, memory always ready
    vec[0]  = '{1, 0, 16'h0,  1, 16'h0,  0, 16'h0};
    vec[1]  = '{1, 0, 16'h0,  1, 16'h1,  0, 16'h0};
    vec[2]  = '{1, 0, 16'h0,  0, 16'h0,  1, 16'h0};
    vec[3]  = '{1, 0, 16'h0,  1, 16'h2,  1, 16'h1};
    vec[4]  = '{1, 0, 16'h0,  1, 16'h3,  0, 16'h0};
    vec[5]  = '{1, 0, 16'h0,  0, 16'h0,  1, 16'h2};
    vec[6]  = '{1, 0, 16'h0,  1, 16'h4,  1, 16'h3};
    vec[7]  = '{1, 0, 16'h0,  1, 16'h5,  0, 16'h0};
    vec[8]  = '{1, 1, 16'h40, 0, 16'h0,  0, 16'h0};
    vec[9]  = '{1, 0, 16'h0,  1, 16'h40, 0, 16'h0};
    vec[10] = '{1, 0, 16'h0,  1, 16'h41, 0, 16'h0};
    vec[11] = '{1, 0, 16'h0,  0, 16'h0,  1, 16'h40};

    do_reset();
    imem_req_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      id_ready = vec[i].idr;
      flush    = vec[i].fl;
      flush_pc = vec[i].fpc;
      step();
      chk("tbl_req_valid", s_rv, vec[i].rv);
      if (vec[i].rv) chk("tbl_addr", s_addr, vec[i].addr);
      chk("tbl_id_valid", s_idv, vec[i].idv);
      if (vec[i].idv) chk("tbl_pc", s_pc, vec[i].pc);
    end
    flush = 1'b0;

    // Decode stalled: only DEPTH requests go out, then both drain in order.
    do_reset();
    imem_req_ready = 1'b1;
    repeat (6) step();
    chk("stall_reqs", n_acc, DEPTH);
    chk("stall_req_valid", s_rv, 0);
    id_ready = 1'b1;
    wait_deliv(2, 20);
    if (deliv_log.size() >= 2) begin
      chk("stall_first", deliv_log[0], 16'h0000);
      chk("stall_second", deliv_log[1], 16'h0001);
    end

    // Latency 3, two requests in flight, then redirect: both old replies are dropped.
    do_reset();
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    lat_min        = 3;
    lat_max        = 3;
    repeat (2) step();
    chk("inflight_reqs", n_acc, 2);
    flush    = 1'b1;
    flush_pc = 16'h0040;
    step();
    flush = 1'b0;
    wait_deliv(1, 30);
    if (deliv_log.size() >= 1) chk("flush_first_pc", deliv_log[0], 16'h0040);

    // Redirect in the very cycle decode would take a valid head.
    do_reset();
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    lat_min        = 1;
    lat_max        = 1;
    k = 0;
    while (!(mq.size() > 0 && mq[0].got) && k < 20) begin
      step();
      k++;
    end
    base     = deliv_log.size();
    flush    = 1'b1;
    flush_pc = 16'h0040;
    step();
    flush = 1'b0;
    chk("flush_pop_idv", s_idv, 0);
    wait_deliv(base + 1, 30);
    if (deliv_log.size() > base) chk("flush_pop_next_pc", deliv_log[base], 16'h0040);

    // PC wrap at the top of the address space.
    flush    = 1'b1;
    flush_pc = 16'hFFFF;
    step();
    flush = 1'b0;
    base  = deliv_log.size();
    wait_deliv(base + 2, 30);
    if (deliv_log.size() >= base + 2) begin
      chk("wrap_pc0", deliv_log[base], 16'hFFFF);
      chk("wrap_pc1", deliv_log[base + 1], 16'h0000);
    end
    if (acc_log.size() >= 2) chk("wrap_req1", acc_log[1], 16'h0000);

    // Asynchronous reset mid-stream with both slots filled.
    do_reset();
    imem_req_ready = 1'b1;
    repeat (4) step();
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst      = 1'b1;
    id_ready = 1'b1;
    wait_deliv(1, 20);
    if (deliv_log.size() >= 1) chk("midrst_restart_pc", deliv_log[0], 16'h0000);

    // Random traffic: ready jitter, latency 1..4, occasional redirects anywhere.
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      id_ready       = ($urandom_range(3, 0) != 0);
      flush          = ($urandom_range(24, 0) == 0);
      flush_pc       = ($urandom_range(7, 0) == 0) ? 16'hFFFE : AW'($urandom);
      step();
    end
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
